// File: rtl/ex_muldiv_if.sv
// Encodings for the EX stage and the id_ex -> EX -> ex_mem port bundle.
package ex_muldiv_pkg;
    localparam int ALUOP_W    = 8;
    localparam int ALUSEL_W   = 3;
    localparam int REG_ADDR_W = 5;

    localparam logic [ALUOP_W-1:0] ALUOP_NOP   = 8'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_AND   = 8'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = 8'd2;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR   = 8'd3;
    localparam logic [ALUOP_W-1:0] ALUOP_NOR   = 8'd4;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL   = 8'd5;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL   = 8'd6;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA   = 8'd7;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 8'd8;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDU  = 8'd9;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 8'd10;
    localparam logic [ALUOP_W-1:0] ALUOP_SUBU  = 8'd11;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 8'd12;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTU  = 8'd13;
    localparam logic [ALUOP_W-1:0] ALUOP_MULT  = 8'd14;
    localparam logic [ALUOP_W-1:0] ALUOP_MULTU = 8'd15;
    localparam logic [ALUOP_W-1:0] ALUOP_DIV   = 8'd16;
    localparam logic [ALUOP_W-1:0] ALUOP_DIVU  = 8'd17;
    localparam logic [ALUOP_W-1:0] ALUOP_MFHI  = 8'd18;
    localparam logic [ALUOP_W-1:0] ALUOP_MFLO  = 8'd19;
    localparam logic [ALUOP_W-1:0] ALUOP_MTHI  = 8'd20;
    localparam logic [ALUOP_W-1:0] ALUOP_MTLO  = 8'd21;

    localparam logic [ALUSEL_W-1:0] ALUSEL_NOP   = 3'd0;
    localparam logic [ALUSEL_W-1:0] ALUSEL_LOGIC = 3'd1;
    localparam logic [ALUSEL_W-1:0] ALUSEL_SHIFT = 3'd2;
    localparam logic [ALUSEL_W-1:0] ALUSEL_ARITH = 3'd3;
    localparam logic [ALUSEL_W-1:0] ALUSEL_MOVE  = 3'd4;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;
endpackage

// Stall protocol: the instruction on aluop_i/alusel_i/rdata*_i is consumed at a
// clock edge only when stallreq_o is low in that cycle; while stallreq_o is high
// the upstream stages must hold the same instruction. A MUL/DIV op raises
// stallreq_o combinationally in its first cycle and drops it in DONE, so the
// held op retires exactly once. dbg_state mirrors the multiply/divide FSM.
interface ex_muldiv_if #(parameter int WIDTH = 32) ();
    logic [ex_muldiv_pkg::ALUOP_W-1:0]    aluop_i;
    logic [ex_muldiv_pkg::ALUSEL_W-1:0]   alusel_i;
    logic [WIDTH-1:0]                     rdata1_i;
    logic [WIDTH-1:0]                     rdata2_i;
    logic [ex_muldiv_pkg::REG_ADDR_W-1:0] waddr_i;
    logic                                 we_i;
    logic [ex_muldiv_pkg::REG_ADDR_W-1:0] waddr_o;
    logic                                 we_o;
    logic [WIDTH-1:0]                     wdata_o;
    logic                                 stallreq_o;
    logic [WIDTH-1:0]                     hi_o;
    logic [WIDTH-1:0]                     lo_o;
    ex_muldiv_pkg::md_state_e             dbg_state;

    modport master (
        output aluop_i, alusel_i, rdata1_i, rdata2_i, waddr_i, we_i,
        input  waddr_o, we_o, wdata_o, stallreq_o, hi_o, lo_o, dbg_state
    );

    modport slave (
        input  aluop_i, alusel_i, rdata1_i, rdata2_i, waddr_i, we_i,
        output waddr_o, we_o, wdata_o, stallreq_o, hi_o, lo_o, dbg_state
    );
endinterface

// File: rtl/ex_muldiv.sv
// Execute stage: single-cycle ALU plus an iterative multiply/divide unit
// (one shift-add or restoring-divide step per cycle) writing HI/LO.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum_res, diff_res, logic_res, shift_res, arith_res;
    logic             add_ovf, sub_ovf, slt_s, slt_u;
    logic [WIDTH-1:0] wdata;
    logic             we;

    logic             is_md, op_div, op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    md_state_e        state_q, state_d;
    logic             stall;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q, raw_a_q;
    logic             is_div_q, neg_q_q, neg_r_q, div_zero_q;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] hi_n, lo_n, hi_fin, lo_fin, hi_q, lo_q;
    logic [2*WIDTH-1:0] prod;

    assign a        = bus.rdata1_i;
    assign b        = bus.rdata2_i;
    assign shamt    = a[SHW-1:0];
    assign sum_res  = a + b;
    assign diff_res = a - b;
    assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_res[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_res[WIDTH-1] != a[WIDTH-1]);
    assign slt_s    = $signed(a) < $signed(b);
    assign slt_u    = a < b;

    assign is_md     = (bus.aluop_i == ALUOP_MULT) || (bus.aluop_i == ALUOP_MULTU) ||
                       (bus.aluop_i == ALUOP_DIV)  || (bus.aluop_i == ALUOP_DIVU);
    assign op_div    = (bus.aluop_i == ALUOP_DIV)  || (bus.aluop_i == ALUOP_DIVU);
    assign op_signed = (bus.aluop_i == ALUOP_MULT) || (bus.aluop_i == ALUOP_DIV);
    assign a_neg     = op_signed && a[WIDTH-1];
    assign b_neg     = op_signed && b[WIDTH-1];
    assign mag_a     = a_neg ? -a : a;
    assign mag_b     = b_neg ? -b : b;

    // Single-cycle result groups: logic, shift and add/sub/compare.
    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        case (bus.aluop_i)
            ALUOP_AND:  logic_res = a & b;
            ALUOP_OR:   logic_res = a | b;
            ALUOP_XOR:  logic_res = a ^ b;
            ALUOP_NOR:  logic_res = ~(a | b);
            ALUOP_SLL:  shift_res = b << shamt;
            ALUOP_SRL:  shift_res = b >> shamt;
            ALUOP_SRA:  shift_res = $unsigned($signed(b) >>> shamt);
            ALUOP_ADD, ALUOP_ADDU: arith_res = sum_res;
            ALUOP_SUB, ALUOP_SUBU: arith_res = diff_res;
            ALUOP_SLT:  arith_res = {{(WIDTH-1){1'b0}}, slt_s};
            ALUOP_SLTU: arith_res = {{(WIDTH-1){1'b0}}, slt_u};
            default: ;
        endcase
    end

    // Writeback mux and write-enable qualification; reset forces a bubble.
    always_comb begin
        wdata = '0;
        we    = bus.we_i;
        case (bus.alusel_i)
            ALUSEL_LOGIC: wdata = logic_res;
            ALUSEL_SHIFT: wdata = shift_res;
            ALUSEL_ARITH: wdata = arith_res;
            ALUSEL_MOVE:  wdata = (bus.aluop_i == ALUOP_MFHI) ? hi_q :
                                  (bus.aluop_i == ALUOP_MFLO) ? lo_q : '0;
            default: ;
        endcase
        if (((bus.aluop_i == ALUOP_ADD) && add_ovf) || ((bus.aluop_i == ALUOP_SUB) && sub_ovf) ||
            is_md || (bus.aluop_i == ALUOP_MTHI) || (bus.aluop_i == ALUOP_MTLO))
            we = 1'b0;
        if (rst) begin
            wdata = '0;
            we    = 1'b0;
        end
    end

    // Multiply/divide FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= MD_IDLE;
        else     state_q <= state_d;
    end

    // Next state and stall request; DONE releases the held op and never restarts.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            MD_IDLE: if (is_md) begin
                state_d = MD_BUSY;
                stall   = 1'b1;
            end
            MD_BUSY: begin
                stall = 1'b1;
                if (cnt_q == {SHW{1'b1}}) state_d = MD_DONE;
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (rst) stall = 1'b0;
    end

    // One iteration: shift-add for multiply, restoring subtract-shift for divide.
    // With rem < divisor the trial difference fits WIDTH bits, so its top bit is the borrow.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[WIDTH];
        if (is_div_q) begin
            hi_n = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_n = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // Operand latch in IDLE and iteration registers in BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            raw_a_q    <= '0;
            is_div_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: if (is_md) begin
                    cnt_q      <= '0;
                    acc_hi_q   <= '0;
                    acc_lo_q   <= op_div ? mag_a : mag_b;
                    opnd_q     <= op_div ? mag_b : mag_a;
                    raw_a_q    <= a;
                    is_div_q   <= op_div;
                    neg_q_q    <= a_neg ^ b_neg;
                    neg_r_q    <= a_neg;
                    div_zero_q <= op_div && (b == '0);
                end
                MD_BUSY: begin
                    cnt_q    <= cnt_q + SHW'(1);
                    acc_hi_q <= hi_n;
                    acc_lo_q <= lo_n;
                end
                default: ;
            endcase
        end
    end

    // Sign correction and divide-by-zero override applied in DONE.
    always_comb begin
        prod = {acc_hi_q, acc_lo_q};
        if (neg_q_q) prod = -prod;
        if (!is_div_q) begin
            {hi_fin, lo_fin} = prod;
        end else if (div_zero_q) begin
            hi_fin = raw_a_q;
            lo_fin = '1;
        end else begin
            hi_fin = neg_r_q ? -acc_hi_q : acc_hi_q;
            lo_fin = neg_q_q ? -acc_lo_q : acc_lo_q;
        end
    end

    // HI/LO: loaded leaving DONE, or directly by MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == MD_DONE) begin
            hi_q <= hi_fin;
            lo_q <= lo_fin;
        end else begin
            if (bus.aluop_i == ALUOP_MTHI) hi_q <= a;
            if (bus.aluop_i == ALUOP_MTLO) lo_q <= a;
        end
    end

    assign bus.waddr_o    = bus.waddr_i;
    assign bus.we_o       = we;
    assign bus.wdata_o    = wdata;
    assign bus.stallreq_o = stall;
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;
    assign bus.dbg_state  = state_q;
endmodule
